// File: rtl/anim_playlist_sequencer.sv
// Animation playlist sequencer: steps frame_idx, repeat count and animation
// select, handshaking each frame with a single-frame driver.
// Optional feature macro: ANIM_SHUFFLE_EN (LFSR-shuffled animation order).
module anim_playlist_sequencer #(
    parameter int NUM_ANIMS       = 5,
    parameter int FRAMES_PER_ANIM = 151,
    parameter int REPEATS         = 2,
    parameter int FRAME_TICKS     = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       stop,
    input  logic       frame_done,
    output logic       frame_start,
    output logic [2:0] anim_sel,
    output logic [7:0] frame_idx,
    output logic       busy,
    output logic       loop_done,
    output logic [1:0] state_dbg
);

    localparam int TICK_W = $clog2(FRAME_TICKS);
    localparam int REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REPEATS - 1);
    localparam logic [7:0]        FRAME_LAST = 8'(FRAMES_PER_ANIM - 1);
    localparam logic [2:0]        ANIM_LAST  = 3'(NUM_ANIMS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_DRIVE   = 2'd2,
        S_ADVANCE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [TICK_W-1:0]  tick;
    logic               done_seen;
    logic [REP_W-1:0]   rep;
    logic               frame_last;
    logic               rep_last;
    logic               anim_wrap;
    logic               anim_adv;
    logic               loop_done_nx;
    logic [2:0]         anim_inc;
    logic [2:0]         anim_nx;

    assign frame_last = (frame_idx == FRAME_LAST);
    assign rep_last   = (rep == REP_LAST);
    assign anim_inc   = (anim_sel == ANIM_LAST) ? 3'd0 : 3'(anim_sel + 3'd1);
    // Animation changes only on an uninterrupted ADVANCE at the last frame of the last repeat.
    assign anim_adv   = (state == S_ADVANCE) && !stop && frame_last && rep_last;
    assign state_dbg  = state;

`ifdef ANIM_SHUFFLE_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_a;
    logic [7:0] lfsr_b;
    logic [7:0] lfsr_nx;
    logic [2:0] cand_a;
    logic [2:0] cand_b;
    logic [2:0] adv_cnt;

    // Fibonacci step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Pick the next animation: one LFSR step, one retry on a repeat, then fall back to +1.
    always_comb begin
        lfsr_a  = lfsr_step(lfsr);
        lfsr_b  = lfsr_step(lfsr_a);
        cand_a  = 3'(lfsr_a % 8'(NUM_ANIMS));
        cand_b  = 3'(lfsr_b % 8'(NUM_ANIMS));
        lfsr_nx = lfsr_a;
        anim_nx = cand_a;
        if (cand_a == anim_sel) begin
            lfsr_nx = lfsr_b;
            anim_nx = (cand_b != anim_sel) ? cand_b : anim_inc;
        end
    end

    // LFSR and advance counter move once per animation advance; the counter marks playlist wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr    <= 8'h01;
            adv_cnt <= 3'd0;
        end else if (anim_adv) begin
            lfsr    <= lfsr_nx;
            adv_cnt <= (adv_cnt == ANIM_LAST) ? 3'd0 : 3'(adv_cnt + 3'd1);
        end
    end

    assign anim_wrap = (adv_cnt == ANIM_LAST);
`else
    assign anim_nx   = anim_inc;
    assign anim_wrap = (anim_sel == ANIM_LAST);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nx;
        end
    end

    // Next-state logic; stop overrides everything, including a pending frame completion.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (which would infer a latch).
        state_nx     = state;
        loop_done_nx = 1'b0;
        if (stop) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (play) state_nx = S_START;
                S_START:   state_nx = S_DRIVE;
                S_DRIVE: begin
                    if ((tick == TICK_LAST) && (done_seen || frame_done)) begin
                        state_nx     = S_ADVANCE;
                        loop_done_nx = frame_last && rep_last && anim_wrap;
                    end
                end
                S_ADVANCE: state_nx = S_START;
                default:   state_nx = S_IDLE;
            endcase
        end
    end

    // Registered outputs, frame timing and playlist position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
            busy        <= 1'b0;
            loop_done   <= 1'b0;
            tick        <= '0;
            done_seen   <= 1'b0;
            rep         <= '0;
            frame_idx   <= 8'd0;
            anim_sel    <= 3'd0;
        end else begin
            frame_start <= (state_nx == S_START);
            busy        <= (state_nx != S_IDLE);
            loop_done   <= loop_done_nx;
            if (state == S_START) begin
                tick      <= '0;
                done_seen <= 1'b0;
            end else if (state == S_DRIVE && !stop) begin
                if (tick != TICK_LAST) tick <= TICK_W'(tick + 1'b1);
                if (frame_done) done_seen <= 1'b1;
            end
            if (state == S_ADVANCE && !stop) begin
                if (frame_last) begin
                    frame_idx <= 8'd0;
                    if (rep_last) begin
                        rep      <= '0;
                        anim_sel <= anim_nx;
                    end else begin
                        rep <= REP_W'(rep + 1'b1);
                    end
                end else begin
                    frame_idx <= 8'(frame_idx + 8'd1);
                end
            end
        end
    end

endmodule
